// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one combinational single-precision multiplier among NREQ requesters.
// Operands are registered ahead of the multiplier and the product is registered after it.
module fp_mul_sched #(
    parameter int NREQ     = 4,
    parameter int MUL_WAIT = 1,
    parameter int CNTW     = 16,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [32*NREQ-1:0]   req_a_i,
    input  logic [32*NREQ-1:0]   req_b_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [31:0]          resp_data_o,
    output logic [IDW-1:0]       resp_id_o,
    output logic                 busy_o,
    output logic [CNTW-1:0]      op_count_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0]      WAIT_INIT = 4'(MUL_WAIT - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]  LAST_ID   = IDW'(NREQ - 1);
    localparam logic [IDW:0]    NREQ_W    = (IDW+1)'(NREQ);

    logic [1:0]      state_q,    state_d;
    logic [IDW-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [31:0]     op_a_q,     op_a_d;
    logic [31:0]     op_b_q,     op_b_d;
    logic [31:0]     res_q,      res_d;
    logic [IDW-1:0]  id_q,       id_d;
    logic [3:0]      wait_q,     wait_d;
    logic [CNTW-1:0] op_count_q, op_count_d;

    logic            grant_found_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [IDW:0]    cand_sum_s;
    logic [IDW:0]    cand_s;
    logic            cand_hit_s;
    logic [31:0]     mul_result_s;
    logic [IDW+4:0]  grant_base_s;

    // Truncating multiplier: no rounding, zero operands force a zero result,
    // exponent simply wraps (no NaN/Inf/overflow handling).
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] prod;
        logic [9:0]  exp_sum;
        logic [22:0] frac;
        logic [31:0] res;
        prod    = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        exp_sum = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127;
        if (prod[47]) begin
            frac    = prod[46:24];
            exp_sum = exp_sum + 10'd1;
        end else begin
            frac    = prod[45:23];
        end
        if ((x == 32'd0) || (y == 32'd0)) begin
            res = 32'd0;
        end else begin
            res = {x[31] ^ y[31], exp_sum[7:0], frac};
        end
        return res;
    endfunction

    assign mul_result_s = fp_mul(op_a_q, op_b_q);

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_sum_s    = '0;
        cand_s        = '0;
        cand_hit_s    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum_s    = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            cand_s        = (cand_sum_s >= NREQ_W) ? (cand_sum_s - NREQ_W) : cand_sum_s;
            cand_hit_s    = !grant_found_s && req_valid_i[cand_s[IDW-1:0]];
            grant_idx_s   = cand_hit_s ? cand_s[IDW-1:0] : grant_idx_s;
            grant_found_s = grant_found_s | cand_hit_s;
        end
    end

    assign grant_base_s = {grant_idx_s, 5'b00000};

    // Next-state logic for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_d      = res_q;
        id_d       = id_q;
        wait_d     = wait_q;
        op_count_d = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    op_a_d   = req_a_i[grant_base_s +: 32];
                    op_b_d   = req_b_i[grant_base_s +: 32];
                    id_d     = grant_idx_s;
                    rr_ptr_d = (grant_idx_s == LAST_ID) ? '0 : (grant_idx_s + IDW'(1));
                    wait_d   = WAIT_INIT;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (wait_q == 4'd0) begin
                    res_d   = mul_result_s;
                    state_d = ST_RESP;
                end else begin
                    wait_d  = wait_q - 4'd1;
                end
            end
            ST_RESP: begin
                // The grant for the next operation waits for the following IDLE cycle.
                if (resp_ready_i) begin
                    state_d    = ST_IDLE;
                    op_count_d = op_count_q + CNTW'(1);
                end else begin
                    state_d    = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            res_q      <= 32'd0;
            id_q       <= '0;
            wait_q     <= 4'd0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_q      <= res_d;
            id_q       <= id_d;
            wait_q     <= wait_d;
            op_count_q <= op_count_d;
        end
    end

    assign req_ready_o  = ((state_q == ST_IDLE) && grant_found_s) ? (ONE_HOT0 << grant_idx_s) : '0;
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_data_o  = res_q;
    assign resp_id_o    = id_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Bench for fp_mul_sched: transaction-level timing/arbitration model checked every cycle,
// directed scenarios with hand-computed products, then randomized traffic.
module tb_fp_mul_sched;

    localparam int NREQ     = 4;
    localparam int MUL_WAIT = 2;
    localparam int CNTW     = 4;
    localparam int IDW      = $clog2(NREQ);

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_data;
    logic [IDW-1:0]      resp_id;
    logic                busy;
    logic [CNTW-1:0]     op_count;

    int checks = 0;
    int errors = 0;

    fp_mul_sched #(.NREQ(NREQ), .MUL_WAIT(MUL_WAIT), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_id_o    (resp_id),
        .busy_o       (busy),
        .op_count_o   (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product from the arithmetic rules: significand product, one-bit normalise, truncate.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned sa, sb, p;
        int e, top;
        logic [22:0] frac;
        if (a == 32'd0 || b == 32'd0) return 32'd0;
        sa   = 64'(a[22:0]) + 64'h80_0000;
        sb   = 64'(b[22:0]) + 64'h80_0000;
        p    = sa * sb;
        top  = (p >= 64'h8000_0000_0000) ? 1 : 0;
        frac = 23'(p >> (23 + top));
        e    = int'(a[30:23]) + int'(b[30:23]) - 127 + top;
        return {a[31] ^ b[31], 8'(e), frac};
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int              cyc = 0;
    bit              m_busy = 0;
    int              m_resp_cyc = 0;
    int              m_id = 0;
    logic [31:0]     m_prod = 32'd0;
    int              m_ptr = 0;
    int              m_cnt = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        bit              exp_rv;
        int              g;
        cyc++;
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_op_count", 32'(op_count), 32'd0);
        end else begin
            exp_rv    = m_busy && (cyc >= m_resp_cyc);
            exp_ready = '0;
            g         = -1;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("model_req_ready", 32'(req_ready), 32'(exp_ready));
            check("model_resp_valid", 32'(resp_valid), 32'(exp_rv));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_op_count", 32'(op_count), 32'(m_cnt % (1 << CNTW)));
            if (exp_rv) begin
                check("model_resp_data", resp_data, m_prod);
                check("model_resp_id", 32'(resp_id), 32'(m_id));
            end
            if (g >= 0) begin
                m_busy     = 1;
                m_id       = g;
                m_prod     = ref_mul(req_a[g*32 +: 32], req_b[g*32 +: 32]);
                m_resp_cyc = cyc + 1 + MUL_WAIT;
                m_ptr      = (g + 1) % NREQ;
            end else if (exp_rv && resp_ready) begin
                m_busy = 0;
                m_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) r = 32'd0;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One request from requester id, response accepted immediately (resp_ready assumed high).
    task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] data, output logic [IDW-1:0] rid, output int lat);
        int n;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_valid[id] = 1'b1;
        data = 32'd0; rid = '0; lat = 0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[id]) break;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL run_one_grant_timeout: requester %0d never granted", id);
        end
        check("run_one_grant_vec", 32'(req_ready), 32'(1) << id);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        for (n = 1; n < 50; n++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL run_one_resp_timeout: requester %0d got no response", id);
        end
        lat  = n;
        data = resp_data;
        rid  = resp_id;
        @(posedge clk); #1;
    endtask

    logic [31:0]     d;
    logic [IDW-1:0]  rid;
    int              lat;
    logic [NREQ-1:0] hs;

    initial begin
        int ng, nr, n;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b1;

        check("pin_2x3", ref_mul(32'h4000_0000, 32'h4040_0000), 32'h40C0_0000);
        check("pin_1p5sq", ref_mul(32'h3FC0_0000, 32'h3FC0_0000), 32'h4010_0000);
        check("pin_neg", ref_mul(32'hC000_0000, 32'h4040_0000), 32'hC0C0_0000);
        check("pin_zero", ref_mul(32'h0000_0000, 32'h42F6_0000), 32'h0000_0000);

        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_data", resp_data, 32'd0);
        check("reset_resp_id", 32'(resp_id), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 1: reset during EXEC aborts the operation
        req_a[31:0] = 32'h4000_0000; req_b[31:0] = 32'h4040_0000;
        req_valid = 4'b0001;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[0]) break;
        end
        check("t1_grant0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        check("t1_busy_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t1_rst_ready", 32'(req_ready), 32'd0);
        check("t1_rst_rv", 32'(resp_valid), 32'd0);
        check("t1_rst_data", resp_data, 32'd0);
        check("t1_rst_id", 32'(resp_id), 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("t1_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        run_one(1, 32'hC000_0000, 32'h4040_0000, d, rid, lat);
        check("t1_data", d, 32'hC0C0_0000);
        check("t1_id", 32'(rid), 32'd1);

        // 2: single request, latency and counter
        do_reset();
        run_one(0, 32'h4000_0000, 32'h4040_0000, d, rid, lat);
        check("t2_data", d, 32'h40C0_0000);
        check("t2_id", 32'(rid), 32'd0);
        check("t2_latency", 32'(lat), 32'(MUL_WAIT + 1));
        check("t2_count", 32'(op_count), 32'd1);

        // 3: all requesters valid, round-robin order
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'h3FC0_0000;
            req_b[i*32 +: 32] = 32'h3FC0_0000;
        end
        req_valid = 4'b1111;
        ng = 0; nr = 0;
        for (n = 0; n < 300 && nr < 5; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("t3_grant", 32'(req_ready), 32'(1) << (ng % 4));
                ng++;
            end
            if (resp_valid) begin
                check("t3_data", resp_data, 32'h4010_0000);
                check("t3_id", 32'(resp_id), 32'(nr % 4));
                nr++;
            end
            @(posedge clk); #1;
            if (ng >= 5) req_valid = '0;
        end
        if (nr < 5) begin
            checks++; errors++;
            $display("FAIL t3_timeout: only %0d responses", nr);
        end
        check("t3_count", 32'(op_count), 32'd5);

        // 4: back-pressure on the response side
        resp_ready = 1'b0;
        req_a[96 +: 32] = 32'h40A0_0000; req_b[96 +: 32] = 32'h3F00_0000;
        req_valid = 4'b1000;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[3]) break;
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        @(posedge clk); #1;
        req_a[31:0] = 32'h4000_0000; req_b[31:0] = 32'h4000_0000;
        req_valid = 4'b0001;
        repeat (10) begin
            @(negedge clk);
            check("t4_rv", 32'(resp_valid), 32'd1);
            check("t4_data", resp_data, 32'h4020_0000);
            check("t4_id", 32'(resp_id), 32'd3);
            check("t4_ready", 32'(req_ready), 32'd0);
            check("t4_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_count", 32'(op_count), 32'd6);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_regrant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        check("t4_next_data", resp_data, 32'h4080_0000);
        check("t4_next_id", 32'(resp_id), 32'd0);
        @(posedge clk); #1;
        check("t4_count2", 32'(op_count), 32'd7);

        // 5a: zero operand
        run_one(2, 32'h0000_0000, 32'h42F6_0000, d, rid, lat);
        check("t5_zero_data", d, 32'h0000_0000);
        check("t5_zero_id", 32'(rid), 32'd2);

        // randomized traffic with random back-pressure
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            resp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req_a[i*32 +: 32] = rand_op();
                        req_b[i*32 +: 32] = rand_op();
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 9) < 3) begin
                    req_valid[i] = 1'b1;
                    req_a[i*32 +: 32] = rand_op();
                    req_b[i*32 +: 32] = rand_op();
                end
            end
        end
        req_valid = '0;
        resp_ready = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL drain_timeout: busy stuck high");
        end
        @(posedge clk); #1;

        // 5b: counter wrap
        do_reset();
        for (int i = 0; i < 15; i++) begin
            run_one(i % NREQ, rand_op(), rand_op(), d, rid, lat);
        end
        check("t5_count_max", 32'(op_count), 32'hF);
        run_one(1, 32'h3F80_0000, 32'h3F80_0000, d, rid, lat);
        check("t5_one_data", d, 32'h3F80_0000);
        check("t5_count_wrap", 32'(op_count), 32'h0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
